pattern_gen: RTL and testbench

//  - Serialises a parallel bit pattern onto a single output line, MSB first, one bit per clock.
//  - Repeats the pattern a programmable number of times per trigger.
//  - Sits between the glitch control logic and the glitch output driver.
//  - Loaded and triggered by a one-cycle enable; rdy reports idle/ready for the next trigger.

---
 rtl/pattern_gen.sv | 125 ++++++++++++
 tb/tb_pattern_gen.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : pattern_gen
// Purpose  : Serialises a latched parallel pattern onto one output line, MSB
//            first, one bit per clock, repeated (pattern_cnt + 1) times per
//            accepted trigger. Feeds the glitch output driver.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_gen #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     pattern,
  input  logic [CNT_WIDTH-1:0] pattern_cnt,
  output logic                 out,
  output logic                 rdy,
  output logic                 done
);

  // Bit-index width kept at least 1 so a 1-bit pattern still elaborates.
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     p_q, p_d;
  logic [CNT_WIDTH-1:0] n_q, n_d;
  logic [CNT_WIDTH-1:0] pass_q, pass_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 out_q, out_d;
  logic                 rdy_q, rdy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     p_rot;

  // The pattern register rotates left each bit time, so after WIDTH bits it
  // holds the original pattern again and the next pass follows with no gap.
  // The rotate is written with shifts so WIDTH=1 still elaborates.
  assign p_rot = (p_q << 1) | (p_q >> (WIDTH - 1));

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so every port comes straight from a flop.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    n_d     = n_q;
    pass_d  = pass_q;
    idx_d   = idx_q;
    out_d   = 1'b0;
    rdy_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (en) begin
          state_d = SHIFT;
          p_d     = pattern;
          n_d     = pattern_cnt;
          pass_d  = '0;
          idx_d   = '0;
          out_d   = pattern[WIDTH-1];
          rdy_d   = 1'b0;
        end
      end
      SHIFT: begin
        p_d = p_rot;
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
          // Pass counter never exceeds the latched N, so a full-scale
          // repeat count cannot wrap the counter before the run ends.
          if (pass_q == n_q) begin
            state_d = IDLE;
            rdy_d   = 1'b1;
            done_d  = 1'b1;
            out_d   = 1'b0;
          end else begin
            pass_d = pass_q + CNT_WIDTH'(1);
            out_d  = p_rot[WIDTH-1];
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
          out_d = p_rot[WIDTH-1];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset takes priority over a trigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      n_q     <= '0;
      pass_q  <= '0;
      idx_q   <= '0;
      out_q   <= 1'b0;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      n_q     <= n_d;
      pass_q  <= pass_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign rdy  = rdy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_gen
// Purpose  : Self-checking bench for pattern_gen. Every triggered run pushes
//            its expected per-cycle {out, rdy, done} values into a queue; a
//            monitor pops one entry per cycle and compares against the DUT.
//            An empty queue means the DUT must be idle {0, 1, 0}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_gen;

  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 8;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic [WIDTH-1:0]     pattern;
  logic [CNT_WIDTH-1:0] pattern_cnt;
  logic                 out;
  logic                 rdy;
  logic                 done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        mon_on   = 1'b0;
  logic [2:0]  exp_q[$];

  pattern_gen #(
    .WIDTH    (WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pattern    (pattern),
    .pattern_cnt(pattern_cnt),
    .out        (out),
    .rdy        (rdy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, expv);
    end
  endtask

  // One clock of stimulus. Inputs are applied just after a rising edge; at the
  // next rising edge the reference model decides what the DUT should do:
  // reset flushes the scoreboard, and a trigger is accepted only when no run
  // is outstanding (empty queue means the previous cycle showed rdy=1).
  task automatic step(input logic e, input logic [WIDTH-1:0] p,
                      input logic [CNT_WIDTH-1:0] c, input logic r);
    en          = e;
    pattern     = p;
    pattern_cnt = c;
    rst         = r;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
    end else if (e && exp_q.size() == 0) begin
      for (int ps = 0; ps <= int'(c); ps++) begin
        for (int b = WIDTH - 1; b >= 0; b--) begin
          exp_q.push_back({p[b], 1'b0, 1'b0});
        end
      end
      exp_q.push_back(3'b011);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  // Per-cycle monitor, sampling on the falling edge away from the active edge.
  always @(negedge clk) begin : mon
    logic [2:0] e;
    if (mon_on) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 3'b010;
      check("cycle{out,rdy,done}", {29'd0, out, rdy, done}, {29'd0, e});
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; pattern = '0; pattern_cnt = '0;
    step(1'b0, 8'h00, 8'h00, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    check("reset_rdy",  {31'd0, rdy},  32'd1);
    check("reset_out",  {31'd0, out},  32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    mon_on = 1'b1;

    // Idle after reset with no trigger.
    idle(6);

    // Single passes of alternating patterns.
    step(1'b1, 8'h55, 8'h00, 1'b0);
    idle(12);
    step(1'b1, 8'hAA, 8'h00, 1'b0);
    idle(12);

    // Three passes back to back.
    step(1'b1, 8'hF0, 8'h02, 1'b0);
    idle(30);

    // Trigger with a different pattern mid-shift must be ignored.
    step(1'b1, 8'h3C, 8'h01, 1'b0);
    idle(4);
    step(1'b1, 8'hC3, 8'h05, 1'b0);
    idle(20);

    // Reset in the middle of an all-ones run with en held high.
    step(1'b1, 8'hFF, 8'h00, 1'b0);
    idle(4);
    step(1'b1, 8'h12, 8'h00, 1'b1);
    step(1'b1, 8'h12, 8'h00, 1'b1);
    step(1'b1, 8'hFF, 8'h00, 1'b0);
    idle(12);

    // en held high: back-to-back runs with exactly one idle cycle between.
    for (int k = 0; k < 30; k++) step(1'b1, 8'hA5, 8'h00, 1'b0);
    idle(12);

    // Full-scale repeat count: 256 passes.
    step(1'b1, 8'h81, 8'hFF, 1'b0);
    idle(2060);

    // A few random runs.
    for (int t = 0; t < 4; t++) begin
      step(1'b1, 8'($urandom), 8'($urandom_range(0, 3)), 1'b0);
      idle(40);
    end

    // Drain with a bound; anything left over is a failure.
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) idle(1);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
